// File: rtl/fifo_burst_drain_pkg.sv
// Shared types for the FIFO burst-drain stage: the two-state drain FSM encoding.
package fifo_burst_drain_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_burst_drain.sv
// Drains a threshold FIFO in whole bursts (or timed-out partial bursts) and
// emits each burst as one AXI-stream packet with TLAST on the final word.
module fifo_burst_drain
    import fifo_burst_drain_pkg::*;
#(
    parameter int BW        = 8,
    parameter int LGFLEN    = 4,
    parameter int LGTIMEOUT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [LGFLEN:0]      i_fill,
    input  logic                 i_empty,
    input  logic [BW-1:0]        i_data,
    output logic                 o_rd,
    input  logic [LGFLEN:0]      i_burst_len,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    output logic                 M_AXIS_TVALID,
    input  logic                 M_AXIS_TREADY,
    output logic [BW-1:0]        M_AXIS_TDATA,
    output logic                 M_AXIS_TLAST,
    output logic                 o_busy
);

    localparam logic [LGFLEN:0] FLEN = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] ONE  = (LGFLEN+1)'(1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LGFLEN:0]        r_remaining;
    logic [LGTIMEOUT-1:0]   r_idle;
    logic [LGFLEN:0]        w_len;
    logic                   w_below;
    logic                   w_full_start;
    logic                   w_flush_start;
    logic                   w_start;
    logic                   w_last_rd;

    // Burst length clamped to 1..FLEN so a zero or oversized request stays sane.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_len = i_burst_len;
        if (i_burst_len == '0)
            w_len = ONE;
        else if (i_burst_len > FLEN)
            w_len = FLEN;
    end

    assign w_below       = !i_empty && (i_fill < w_len);
    assign w_full_start  = (r_state == ST_IDLE) && (i_fill >= w_len);
    assign w_flush_start = (r_state == ST_IDLE) && (i_timeout != '0) && w_below
                           && (r_idle == i_timeout);
    assign w_start       = w_full_start || w_flush_start;

    // A new read is allowed only if the output register is empty or draining this cycle.
    assign o_rd = !i_reset && (r_state == ST_BURST) && (r_remaining != '0) && !i_empty
                  && (!M_AXIS_TVALID || M_AXIS_TREADY);

    assign w_last_rd = o_rd && (r_remaining == ONE);
    assign o_busy    = (r_state == ST_BURST) || M_AXIS_TVALID;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_BURST;
            ST_BURST: if (w_last_rd || r_remaining == '0) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_idle      <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_IDLE) begin
                if (w_full_start)
                    r_remaining <= w_len;
                else if (w_flush_start)
                    r_remaining <= i_fill;
            end else if (o_rd) begin
                r_remaining <= r_remaining - ONE;
            end

            if (r_state != ST_IDLE || i_empty || w_start)
                r_idle <= '0;
            else if (w_below && r_idle != '1)
                r_idle <= r_idle + LGTIMEOUT'(1);
        end
    end

    // Output register: load on a read, drop valid once accepted with nothing behind it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
        end else if (o_rd) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= (r_remaining == ONE);
            M_AXIS_TDATA  <= i_data;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end
    end

endmodule
